// File: rtl/nios_cpu_pllcfg_status_pio.sv
// Avalon-MM status PIO for PLL configuration inputs: synchronised inputs,
// per-bit edge capture with write-1-to-clear, interrupt mask and level IRQ.

module nios_cpu_pllcfg_status_pio_lane #(
  parameter int EDGE_TYPE = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  input  logic det_en,
  input  logic mask_we,
  input  logic mask_d,
  input  logic clr,
  output logic mask,
  output logic cap
);
  logic prev;
  logic edge_hit;

  always_comb begin
    edge_hit = 1'b0;
    case (EDGE_TYPE)
      0:       edge_hit = d & ~prev;
      1:       edge_hit = ~d & prev;
      default: edge_hit = d ^ prev;
    endcase
  end

  // A new edge wins over a same-cycle clear so no event is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b0;
      mask <= 1'b0;
      cap  <= 1'b0;
    end else begin
      prev <= d;
      if (mask_we) mask <= mask_d;
      cap <= (cap & ~clr) | (edge_hit & det_en);
    end
  end
endmodule

module nios_cpu_pllcfg_status_pio #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clr_bits;
  logic [2:0]       warm_cnt;
  logic             det_en;
  logic             wr_en;
  logic             mask_we;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign data_in = in_port;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= in_port;
          for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
      end
      assign data_in = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Hold off detection until the sync chain and prev_in carry real input,
  // otherwise the reset zeros look like edges against a high input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                warm_cnt <= '0;
    else if (warm_cnt != WARM_MAX) warm_cnt <= warm_cnt + 3'd1;
  end
  assign det_en = (warm_cnt == WARM_MAX);

  assign wr_en    = chipselect & ~write_n;
  assign mask_we  = wr_en && (address == 2'd2);
  assign clr_bits = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;
  assign unused_wd = &{1'b0, writedata};

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      nios_cpu_pllcfg_status_pio_lane #(.EDGE_TYPE(EDGE_TYPE)) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (data_in[i]),
        .det_en  (det_en),
        .mask_we (mask_we),
        .mask_d  (writedata[i]),
        .clr     (clr_bits[i]),
        .mask    (irqmask[i]),
        .cap     (edgecapture[i])
      );
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = data_in;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edgecapture & irqmask);
endmodule
